instr_encode_loader: RTL and testbench

Encoder-side counterpart of the processor's opcode/control decode. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words in the processor's R/I/JI/JII formats. It then writes each word sequentially into instruction memory through a single write port. It sits between the test/boot loader and the imem write port, so programs can be built from fields instead of hand-assembled hex.

---
 rtl/instr_pkg.sv | 32 +++
 rtl/instr_packer.sv | 48 ++++
 rtl/instr_encode_loader.sv | 121 ++++++++++++
 tb/tb_instr_encode_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-set constants: opcodes, field positions and loader FSM states.
// The opcode constants are also used by the control decode.
package instr_pkg;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_J     = 5'd1;
  localparam logic [4:0] OP_BNE   = 5'd2;
  localparam logic [4:0] OP_JAL   = 5'd3;
  localparam logic [4:0] OP_JR    = 5'd4;
  localparam logic [4:0] OP_ADDI  = 5'd5;
  localparam logic [4:0] OP_BLT   = 5'd6;
  localparam logic [4:0] OP_SW    = 5'd7;
  localparam logic [4:0] OP_LW    = 5'd8;

  // Low bit of each field within the 32-bit instruction word
  localparam int OP_LSB     = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int SHAMT_LSB  = 7;
  localparam int ALUOP_LSB  = 2;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/instr_packer.sv
// Combinational field-to-word packer for the R/I/JI/JII instruction formats.
// Bits not used by the selected format stay zero; unknown opcodes clear legal.
module instr_packer
  import instr_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  shamt,
  input  logic [4:0]  aluop,
  input  logic [16:0] imm,
  input  logic [26:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    word[OP_LSB +: 5] = opcode;
    case (opcode)
      OP_RTYPE: begin
        word[RD_LSB +: 5]    = rd;
        word[RS_LSB +: 5]    = rs;
        word[RT_LSB +: 5]    = rt;
        word[SHAMT_LSB +: 5] = shamt;
        word[ALUOP_LSB +: 5] = aluop;
      end
      OP_BNE, OP_ADDI, OP_BLT, OP_SW, OP_LW: begin
        word[RD_LSB +: 5]   = rd;
        word[RS_LSB +: 5]   = rs;
        word[IMM_LSB +: 17] = imm;
      end
      OP_J, OP_JAL: begin
        word[TARGET_LSB +: 27] = target;
      end
      OP_JR: begin
        word[RD_LSB +: 5] = rd;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts decoded instruction fields, packs them into 32-bit words and writes
// them sequentially into instruction memory, one word per two cycles.
module instr_encode_loader
  import instr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_opcode,
  input  logic [4:0]            req_rd,
  input  logic [4:0]            req_rs,
  input  logic [4:0]            req_rt,
  input  logic [4:0]            req_shamt,
  input  logic [4:0]            req_aluop,
  input  logic [16:0]           req_imm,
  input  logic [26:0]           req_target,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err,
  output logic [4:0]            err_opcode
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                  state_reg;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [31:0]             data_reg;
  logic [ADDR_WIDTH:0]     count_reg;
  logic                    full_reg;
  logic                    err_reg;
  logic [4:0]              err_opcode_reg;

  logic [31:0]             packed_word;
  logic                    packed_legal;

  instr_packer u_packer (
    .opcode (req_opcode),
    .rd     (req_rd),
    .rs     (req_rs),
    .rt     (req_rt),
    .shamt  (req_shamt),
    .aluop  (req_aluop),
    .imm    (req_imm),
    .target (req_target),
    .word   (packed_word),
    .legal  (packed_legal)
  );

  assign req_ready = (state_reg == ST_IDLE) && !clear;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      count_reg      <= '0;
      full_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_opcode_reg <= '0;
    end else if (clear) begin
      // imem_data is deliberately kept: it always reflects the last accepted word
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      count_reg      <= '0;
      full_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_opcode_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            if (packed_legal) begin
              data_reg  <= packed_word;
              we_reg    <= 1'b1;
              state_reg <= ST_WRITE;
            end else begin
              err_reg        <= 1'b1;
              err_opcode_reg <= req_opcode;
              state_reg      <= ST_ERR;
            end
          end
        end
        ST_WRITE: begin
          we_reg    <= 1'b0;
          count_reg <= count_reg + 1'b1;
          if (addr_reg == LAST_ADDR) begin
            full_reg  <= 1'b1;
            state_reg <= ST_FULL;
          end else begin
            addr_reg  <= addr_reg + 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_FULL, ST_ERR: begin
          state_reg <= state_reg;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // A clear arriving in the write cycle must suppress the strobe already on the wire
  assign imem_we    = we_reg && !clear;
  assign imem_addr  = addr_reg;
  assign imem_data  = data_reg;
  assign count      = count_reg;
  assign full       = full_reg;
  assign err        = err_reg;
  assign err_opcode = err_opcode_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomized self-checking bench for instr_encode_loader against a
// transaction-level model (encoding by arithmetic, words-written counter).
module tb_instr_encode_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clock;
  logic          reset_n;
  logic          clear;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_opcode, req_rd, req_rs, req_rt, req_shamt, req_aluop;
  logic [16:0]   req_imm;
  logic [26:0]   req_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  logic [4:0]    err_opcode;

  instr_encode_loader #(.ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_rd     (req_rd),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_shamt  (req_shamt),
    .req_aluop  (req_aluop),
    .req_imm    (req_imm),
    .req_target (req_target),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .count      (count),
    .full       (full),
    .err        (err),
    .err_opcode (err_opcode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  int          m_count  = 0;
  int          m_writes = 0;
  bit          m_err    = 0;
  logic [4:0]  m_err_op = '0;
  logic [31:0] m_data   = '0;

  int strobe_cnt = 0;
  realtime accept_t = 0;
  realtime prev_accept_t = 0;

  always @(negedge clock) begin
    #2;
    if (imem_we === 1'b1) strobe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] op, rd, rs, rt, sh, alu, imm, tgt);
    logic [31:0] w;
    w = op * 32'd134217728;
    if (op == 0)              w = w + rd * 32'd4194304 + rs * 32'd131072 + rt * 32'd4096 + sh * 32'd128 + alu * 32'd4;
    else if (op == 1 || op == 3) w = w + tgt;
    else if (op == 4)         w = w + rd * 32'd4194304;
    else                      w = w + rd * 32'd4194304 + rs * 32'd131072 + imm;
    return w;
  endfunction

  task automatic check_status(input string tag);
    bit m_full;
    #1;
    m_full = (m_count == DEPTH);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_full"}, 32'(full), 32'(m_full));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_errop"}, 32'(err_opcode), 32'(m_err_op));
    chk({tag, "_data"}, imem_data, m_data);
    chk({tag, "_addr"}, 32'(imem_addr), m_full ? 32'(DEPTH - 1) : 32'(m_count));
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'(!(m_err || m_full)));
  endtask

  // Presents one request and follows it through accept, strobe and status update.
  // Leaves req_valid high so callers can chain back-to-back requests.
  task automatic send(input logic [4:0] op, rd, rs, rt, sh, alu,
                      input logic [16:0] imm, input logic [26:0] tgt);
    bit got;
    logic [31:0] exp;
    req_opcode = op; req_rd = rd; req_rs = rs; req_rt = rt;
    req_shamt = sh; req_aluop = alu; req_imm = imm; req_target = tgt;
    req_valid = 1'b1;
    got = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (req_ready) begin got = 1; break; end
      @(negedge clock); #1;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    prev_accept_t = accept_t;
    accept_t = $realtime;
    @(negedge clock); #1;
    if (op <= 5'd8) begin
      exp = model_word(32'(op), 32'(rd), 32'(rs), 32'(rt), 32'(sh), 32'(alu), 32'(imm), 32'(tgt));
      chk("strobe_we", 32'(imem_we), 32'd1);
      chk("strobe_addr", 32'(imem_addr), 32'(m_count));
      chk("strobe_data", imem_data, exp);
      $display("txn write op=%0d addr=%0d data=0x%08h", op, imem_addr, imem_data);
      m_data = exp;
      m_count++;
      m_writes++;
    end else begin
      chk("illegal_we", 32'(imem_we), 32'd0);
      $display("txn illegal op=%0d err=%0b err_opcode=%0d", op, err, err_opcode);
      m_err = 1;
      m_err_op = op;
    end
    chk("busy_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    check_status("post");
  endtask

  // Holds a request while the block is full or in error; nothing may be accepted.
  task automatic reject(input logic [4:0] op);
    req_opcode = op; req_rd = 5'($urandom); req_rs = 5'($urandom);
    req_imm = 17'($urandom); req_target = 27'($urandom);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("reject_ready", 32'(req_ready), 32'd0);
      chk("reject_we", 32'(imem_we), 32'd0);
      @(negedge clock);
    end
    req_valid = 1'b0;
    $display("txn rejected op=%0d full=%0b err=%0b", op, full, err);
    check_status("reject");
  endtask

  task automatic do_clear(input bit with_valid);
    int s0;
    s0 = strobe_cnt;
    clear = 1'b1;
    req_valid = with_valid;
    req_opcode = 5'($urandom_range(0, 8));
    #1;
    chk("clear_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    req_valid = 1'b0;
    m_count = 0;
    m_err = 0;
    m_err_op = '0;
    $display("txn clear with_valid=%0b", with_valid);
    check_status("clear");
    chk("clear_no_strobe", 32'(strobe_cnt), 32'(s0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset_n = 1'b0; clear = 1'b0; req_valid = 1'b0;
    req_opcode = '0; req_rd = '0; req_rs = '0; req_rt = '0;
    req_shamt = '0; req_aluop = '0; req_imm = '0; req_target = '0;
    repeat (2) @(negedge clock);
    check_status("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // add $1,$2,$3
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0);
    req_valid = 1'b0;
    chk("add_word", imem_data, 32'h00443000);
    // addi $4,$5,-1 then j 100
    send(5'd5, 5'd4, 5'd5, 5'd0, 5'd0, 5'd7, 17'h1FFFF, 27'd0);
    req_valid = 1'b0;
    chk("addi_word", imem_data, 32'h290BFFFF);
    send(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd100);
    req_valid = 1'b0;
    chk("j_word", imem_data, 32'h08000064);
    do_clear(1'b0);

    // Back-to-back with valid held high
    s0 = strobe_cnt;
    send(5'd7, 5'd9, 5'd3, 5'd0, 5'd0, 5'd0, 17'd12, 27'd0);
    send(5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0);
    chk("b2b_gap1", 32'(int'((accept_t - prev_accept_t) / 10.0)), 32'd2);
    send(5'd2, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 17'h10001, 27'd0);
    req_valid = 1'b0;
    chk("b2b_gap2", 32'(int'((accept_t - prev_accept_t) / 10.0)), 32'd2);
    chk("b2b_strobes", 32'(strobe_cnt - s0), 32'd3);
    do_clear(1'b1);

    // Illegal opcode, then clear and write from address 0 again
    send(5'd9, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1);
    reject(5'd0);
    do_clear(1'b0);

    // Fill the memory: 4 writes then the 5th is refused
    for (int i = 0; i < 4; i++)
      send(5'd8, 5'(i), 5'(i + 1), 5'd0, 5'd0, 5'd0, 17'(i * 3), 27'd0);
    req_valid = 1'b0;
    reject(5'd3);
    do_clear(1'b0);

    // Clear in the write cycle cancels the strobe
    req_opcode = 5'd3; req_target = 27'h5A5A5A5; req_valid = 1'b1;
    #1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clear_cancel_we", 32'(imem_we), 32'd0);
    m_data = model_word(32'd3, 0, 0, 0, 0, 0, 0, 32'h05A5A5A5);
    @(negedge clock);
    clear = 1'b0;
    m_count = 0;
    check_status("clear_cancel");

    // Reset in the write cycle aborts the strobe and zeroes outputs at once
    send(5'd6, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 17'd77, 27'd0);
    req_opcode = 5'd5; req_imm = 17'd5; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_data", imem_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    m_count = 0; m_err = 0; m_err_op = '0; m_data = '0;
    @(negedge clock);
    reset_n = 1'b1;
    check_status("rst_release");

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      @(negedge clock);
      if (m_err || m_count == DEPTH) begin
        if ($urandom_range(0, 2) == 0) reject(5'($urandom));
        else do_clear(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 15) == 0) begin
        do_clear(1'($urandom_range(0, 1)));
      end else begin
        logic [4:0] op;
        op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             17'($urandom), 27'($urandom));
        req_valid = 1'b0;
      end
    end

    @(negedge clock);
    chk("total_strobes", 32'(strobe_cnt), 32'(m_writes));
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
